// File: rtl/wb_trace_reader.sv
// Captures PipeLine writeback records (pc, rwd, wb_data) into a circular FIFO
// and drains each record as a two-beat valid/ready stream: pc first, wb_data second.
module wb_trace_reader #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cap_en,
  input  logic [31:0]              pc,
  input  logic [4:0]               rwd,
  input  logic [31:0]              wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic                     out_first,
  output logic [4:0]               out_rwd,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [DROP_W-1:0]        drop_count,
  output logic [1:0]               dbg_state
);

  // Stream handshake: a beat transfers on a rising clk where out_valid && out_ready.
  // Once out_valid is high, it and the beat contents hold until that transfer.

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [68:0]     mem [DEPTH];
  logic [68:0]     head;
  logic            full, push, wr_en, drop, pop;

  assign full  = (fifo_count == CW'(DEPTH));
  assign push  = cap_en && (rwd != 5'd0);
  assign wr_en = push && !full;
  assign drop  = push && full;
  assign pop   = (state == BEAT1) && out_ready;
  assign head  = mem[rd_ptr];
  assign dbg_state = state;

  // Contents are not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {pc, rwd, wb_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_count <= '0;
    end else begin
      state <= state_next;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop && (drop_count != {DROP_W{1'b1}}))
        drop_count <= drop_count + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    out_first  = 1'b0;
    out_data   = 32'd0;
    out_rwd    = 5'd0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) state_next = BEAT0;
      end
      BEAT0: begin
        out_valid = 1'b1;
        out_first = 1'b1;
        out_data  = head[68:37];
        out_rwd   = head[36:32];
        if (out_ready) state_next = BEAT1;
      end
      BEAT1: begin
        out_valid = 1'b1;
        out_data  = head[31:0];
        out_rwd   = head[36:32];
        // Decide on the pre-pop count so back-to-back records skip IDLE.
        if (out_ready) state_next = (fifo_count > CW'(1)) ? BEAT0 : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
